// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one MMU port among NUM_REQ requesters, one transaction in flight.
// Grant is combinational in IDLE; the MMU request follows one cycle later; responses are routed back.
module mem_arbiter #(
  parameter int MEM_W   = 32,
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*32-1:0]      addr_i,
  input  logic [NUM_REQ-1:0]         we_i,
  input  logic [NUM_REQ*MEM_W/8-1:0] be_i,
  input  logic [NUM_REQ*MEM_W-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [NUM_REQ-1:0]         rvalid_o,
  output logic [NUM_REQ-1:0]         err_o,
  output logic [MEM_W-1:0]           rdata_o,
  output logic                       mem_req_o,
  output logic [31:0]                mem_addr_o,
  output logic                       mem_we_o,
  output logic [MEM_W/8-1:0]         mem_be_o,
  output logic [MEM_W-1:0]           mem_wdata_o,
  input  logic                       mem_rvalid_i,
  input  logic                       mem_err_i,
  input  logic [MEM_W-1:0]           mem_rdata_i,
  output logic                       busy_o,
  output logic                       stray_resp_o
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BE_W  = MEM_W / 8;
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [31:0]        addr_q, addr_d;
  logic               we_q, we_d;
  logic [BE_W-1:0]    be_q, be_d;
  logic [MEM_W-1:0]   wdata_q, wdata_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               stray_q, stray_d;

  logic [31:0]        addr_a  [NUM_REQ];
  logic [BE_W-1:0]    be_a    [NUM_REQ];
  logic [MEM_W-1:0]   wdata_a [NUM_REQ];
  logic [IDX_W-1:0]   win, cand;
  logic               found;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = addr_i[g*32 +: 32];
    assign be_a[g]    = be_i[g*BE_W +: BE_W];
    assign wdata_a[g] = wdata_i[g*MEM_W +: MEM_W];
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    stray_d   = stray_q;
    gnt_o     = '0;
    rvalid_o  = '0;
    err_o     = '0;
    rdata_o   = '0;
    mem_req_o = 1'b0;
    found     = 1'b0;
    win       = '0;
    cand      = '0;

    // Search upward starting just past the last winner.
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_q) + 1 + k) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end

    case (state_q)
      IDLE: begin
        if (mem_rvalid_i || mem_err_i) stray_d = 1'b1;
        if (found) begin
          gnt_o[win] = 1'b1;
          last_d     = win;
          addr_d     = addr_a[win];
          we_d       = we_i[win];
          be_d       = be_a[win];
          wdata_d    = wdata_a[win];
          state_d    = ISSUE;
        end
      end
      ISSUE, WAIT: begin
        if (state_q == ISSUE) begin
          mem_req_o = 1'b1;
          cnt_d     = '0;
          state_d   = WAIT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
        // Error beats rvalid; timeout fires only when the MMU stays silent.
        if (mem_err_i) begin
          err_o[last_q] = 1'b1;
          state_d       = IDLE;
        end else if (mem_rvalid_i) begin
          rvalid_o[last_q] = 1'b1;
          rdata_o          = mem_rdata_i;
          state_d          = IDLE;
        end else if (state_q == WAIT && cnt_q + 16'd1 == TO_LIMIT) begin
          err_o[last_q] = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      gnt_o     = '0;
      rvalid_o  = '0;
      err_o     = '0;
      rdata_o   = '0;
      mem_req_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(NUM_REQ - 1);
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      stray_q <= stray_d;
    end
  end

  assign mem_addr_o   = addr_q;
  assign mem_we_o     = we_q;
  assign mem_be_o     = be_q;
  assign mem_wdata_o  = wdata_q;
  assign busy_o       = (state_q != IDLE);
  assign stray_resp_o = stray_q;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter sharing the single MMU memory port among NUM_REQ requesters: Ibex instruction fetch, Ibex data and the Vicuna vector unit. It sits between the cores and the MMU. It grants one requester at a time and captures that requester's request fields. It then issues a one-cycle request to the MMU, holds until the MMU responds or a timeout expires, and routes the response back to the granted requester only.

## Interface
Parameters:
- MEM_W, 32, data bus width in bits; matches the MMU and vproc_top.
- NUM_REQ, 3, number of requesters; index 0 = instruction fetch, 1 = data, 2 = vector unit.
- TIMEOUT, 255, maximum cycles spent waiting for an MMU response before an error is returned to the requester; 1..65535.

Ports:
- clk  in  1  single clock. All state updates on the rising edge.
- rst  in  1  reset. Synchronous and active-high.
- req_i  in  NUM_REQ  per-requester request; held high until the matching gnt_o pulse.
- addr_i  in  NUM_REQ×32  per-requester byte address.
- we_i  in  NUM_REQ  per-requester write enable; 1 = write.
- be_i  in  NUM_REQ×MEM_W/8  per-requester byte enables.
- wdata_i  in  NUM_REQ×MEM_W  per-requester write data.
- gnt_o  out  NUM_REQ  one-hot grant pulse; one cycle wide.
- rvalid_o  out  NUM_REQ  one-hot response-valid pulse.
- err_o  out  NUM_REQ  one-hot error pulse.
- rdata_o  out  MEM_W  response data, shared by all requesters; valid only while rvalid_o is non-zero.
- mem_req_o  out  1  MMU request pulse.
- mem_addr_o  out  32  captured address driven to the MMU.
- mem_we_o  out  1  captured write enable driven to the MMU.
- mem_be_o  out  MEM_W/8  captured byte enables driven to the MMU.
- mem_wdata_o  out  MEM_W  captured write data driven to the MMU.
- mem_rvalid_i  in  1  MMU response valid.
- mem_err_i  in  1  MMU error.
- mem_rdata_i  in  MEM_W  MMU read data.
- busy_o  out  1  high whenever the arbiter is not in IDLE.
- stray_resp_o  out  1  sticky flag; set by an MMU response that arrives while the arbiter is in IDLE.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_i bit is high, choose the winner by searching upward from (last_grant+1) mod NUM_REQ.
  - Assert gnt_o[winner] combinationally in the same cycle.
  - Capture addr/we/be/wdata of the winner, set last_grant = winner, and go to ISSUE.
  - If no req_i bit is high, stay in IDLE.
- ISSUE:
  - mem_req_o=1 for exactly one cycle; mem_* fields carry the captured values.
  - Clear the timeout counter and go to WAIT, unless a response arrives in this same cycle (see Response).
- WAIT:
  - mem_req_o=0; mem_* fields hold the captured values.
  - The timeout counter increments each cycle.
- Response, in ISSUE or WAIT:
  - If mem_err_i=1, pulse err_o[winner]; rvalid_o stays 0, even when mem_rvalid_i=1 in the same cycle (error wins).
  - Else if mem_rvalid_i=1, pulse rvalid_o[winner] with rdata_o = mem_rdata_i. This is combinational pass-through.
  - Writes complete through the same response path.
  - Next state is IDLE.
- Timeout: when the counter reaches TIMEOUT in WAIT with no response, pulse err_o[winner] and go to IDLE.
- An MMU response arriving in IDLE, including a late response after a timeout, is dropped: no rvalid_o/err_o pulse, and stray_resp_o is set.
- Only one transaction is outstanding at any time; gnt_o is possible only in IDLE.

## Timing
- Reset values:
  - State IDLE; last_grant = NUM_REQ-1, so requester 0 has top priority first.
  - All outputs 0, including captured fields, stray_resp_o and busy_o.
- Reset asserted mid-transaction:
  - Abort next edge with no err_o/rvalid_o pulse.
  - An MMU response in the cycle after reset is treated as stray.
- Latency:
  - Request seen in cycle 0 → gnt_o in cycle 0, mem_req_o in cycle 1.
  - Earliest response forwarded in cycle 1; the next grant is possible in cycle 2.
- Back-to-back throughput is at most one transaction per 2 cycles.
- req_i, addr_i, we_i, be_i and wdata_i are sampled only in the cycle of grant.
- The timeout counter is 16 bits.

## Test plan
- Single requester: req_i=001, addr_i[0]=0x1004; MMU answers rvalid with 0xDEADBEEF two cycles after mem_req_o → gnt_o=001 in cycle 0, mem_req_o with addr 0x1004 in cycle 1, rvalid_o=001 with rdata_o=0xDEADBEEF in cycle 3, busy_o low in cycle 4.
- All three requesters held high continuously after reset, MMU responds immediately → grants in order 001, 010, 100, 001.
- Captured fields: requester 2 write, be=0xF, wdata=0x12345678; requester 2 changes addr_i after grant → mem_* fields stay on the captured values until the response.
- MMU asserts mem_rvalid_i and mem_err_i together for requester 1 → err_o=010, rvalid_o=000.
- TIMEOUT=4 and the MMU is silent → err_o[winner] pulses after 4 WAIT cycles; a later mem_rvalid_i sets stray_resp_o and produces no rvalid_o.
- rst asserted in WAIT → next cycle IDLE with all outputs 0; a following requester-1 request is granted normally.
